// File: rtl/add_accumulator.sv
// Streaming accumulator driving a carry-skip adder core.
// Sums a handshaked operand stream and returns the total with sticky flags.
module CSA #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         overflow
);
    localparam int NB = N / 4;

    // 4-bit ripple blocks; a fully propagating block passes its carry-in straight through
    always_comb begin
        logic c;
        logic rc;
        logic p;
        logic pall;
        int   k;
        sum = '0;
        c   = cin;
        for (int g = 0; g < NB; g++) begin
            rc   = c;
            pall = 1'b1;
            for (int i = 0; i < 4; i++) begin
                k      = 4 * g + i;
                p      = a[k] ^ b[k];
                sum[k] = p ^ rc;
                rc     = (a[k] & b[k]) | (p & rc);
                pall   = pall & p;
            end
            c = pall ? c : rc;
        end
        cout = c;
    end

    assign overflow = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
endmodule

module add_accumulator #(
    parameter int N     = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     init,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     acc_out,
    output logic             carry_flag,
    output logic             ovf_flag,
    output logic [CNT_W-1:0] count
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_d;

    logic [N-1:0] b_op;
    logic [N-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         hs;

    assign b_op = in_sub ? ~in_data : in_data;

    CSA #(.N(N)) u_csa (
        .a        (acc_out),
        .b        (b_op),
        .cin      (in_sub),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign hs        = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start) state_d = ACCUM;
                ACCUM:   if (hs && in_last) state_d = DONE;
                DONE:    if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_out    <= '0;
            carry_flag <= 1'b0;
            ovf_flag   <= 1'b0;
            count      <= '0;
        end else if (clear) begin
            acc_out    <= '0;
            carry_flag <= 1'b0;
            ovf_flag   <= 1'b0;
            count      <= '0;
        end else if (state == IDLE && start) begin
            acc_out    <= init;
            carry_flag <= 1'b0;
            ovf_flag   <= 1'b0;
            count      <= '0;
        end else if (hs) begin
            acc_out    <= sum;
            carry_flag <= carry_flag | cout;
            ovf_flag   <= ovf_flag | overflow;
            if (count != {CNT_W{1'b1}}) count <= count + 1'b1;
        end
    end
endmodule

// File: tb/tb_add_accumulator.sv
// Scoreboard bench for add_accumulator (N=32, CNT_W=4).
// A reference model predicts each stream's result; results are popped on out_valid.
module tb_add_accumulator;
    localparam int N     = 32;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [N-1:0]     acc;
        logic             c;
        logic             o;
        logic [CNT_W-1:0] cnt;
    } res_t;

    logic             clk = 0;
    logic             rst = 1;
    logic             start = 0;
    logic [N-1:0]     init = '0;
    logic             clear = 0;
    logic             in_valid = 0;
    logic             in_ready;
    logic [N-1:0]     in_data = '0;
    logic             in_sub = 0;
    logic             in_last = 0;
    logic             out_valid;
    logic             out_ready = 0;
    logic [N-1:0]     acc_out;
    logic             carry_flag;
    logic             ovf_flag;
    logic [CNT_W-1:0] count;

    int checks = 0;
    int errors = 0;

    res_t         sb[$];
    logic [N-1:0] ops_d[32];
    logic         ops_s[32];

    logic [N-1:0]     m_acc;
    logic             m_c;
    logic             m_o;
    logic [CNT_W-1:0] m_cnt;

    always #5 clk = ~clk;

    add_accumulator #(.N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .init       (init),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sub     (in_sub),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .acc_out    (acc_out),
        .carry_flag (carry_flag),
        .ovf_flag   (ovf_flag),
        .count      (count)
    );

    task automatic model_step(input logic [N-1:0] d, input logic s);
        logic [N:0]   wide;
        logic [N-1:0] b;
        b    = s ? ~d : d;
        wide = {1'b0, m_acc} + {1'b0, b} + {{N{1'b0}}, s};
        m_c  = m_c | wide[N];
        if (m_acc[N-1] == b[N-1] && wide[N-1] != m_acc[N-1]) m_o = 1'b1;
        m_acc = wide[N-1:0];
        if (m_cnt != 4'hF) m_cnt = m_cnt + 1'b1;
    endtask

    task automatic run_stream(input logic [N-1:0] iv, input int n, input bit gap);
        res_t r;
        @(negedge clk);
        start = 1; init = iv;
        @(negedge clk);
        start = 0;
        m_acc = iv; m_c = 0; m_o = 0; m_cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                start = 1; init = 32'hDEAD_BEEF;
                @(negedge clk);
                start = 0;
            end
            in_valid = 1; in_data = ops_d[i]; in_sub = ops_s[i];
            in_last = (i == n - 1);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL in_ready op%0d got %b want 1", i, in_ready);
            end
            @(negedge clk);
            model_step(ops_d[i], ops_s[i]);
            in_valid = 0; in_last = 0;
            checks++;
            if (acc_out !== m_acc) begin
                errors++;
                $display("FAIL acc_step op%0d got %h want %h", i, acc_out, m_acc);
            end
        end
        r = '{acc: m_acc, c: m_c, o: m_o, cnt: m_cnt};
        sb.push_back(r);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_valid_latency got %b want 1", out_valid);
        end
    endtask

    task automatic collect(input int hold);
        res_t e;
        int t;
        t = 0;
        while (out_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL collect_timeout out_valid %b queue %0d", out_valid, sb.size());
            return;
        end
        e = sb.pop_front();
        checks++;
        if ({acc_out, carry_flag, ovf_flag, count} !== e) begin
            errors++;
            $display("FAIL result got acc %h c %b o %b n %0d want acc %h c %b o %b n %0d",
                     acc_out, carry_flag, ovf_flag, count, e.acc, e.c, e.o, e.cnt);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, acc_out, carry_flag, ovf_flag, count} !== {2'b10, e}) begin
                errors++;
                $display("FAIL hold cyc%0d got v %b r %b acc %h want v 1 r 0 acc %h",
                         i, out_valid, in_ready, acc_out, e.acc);
            end
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || acc_out !== e.acc) begin
            errors++;
            $display("FAIL release got v %b r %b acc %h want v 0 r 0 acc %h",
                     out_valid, in_ready, acc_out, e.acc);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({acc_out, carry_flag, ovf_flag, count, in_ready, out_valid} !== '0) begin
            errors++;
            $display("FAIL reset_vals acc %h c %b o %b n %0d r %b v %b",
                     acc_out, carry_flag, ovf_flag, count, in_ready, out_valid);
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        start = 1; init = 32'h1234_5678;
        @(negedge clk);
        start = 0;
        in_valid = 1; in_data = 32'h11; in_sub = 0;
        @(negedge clk);
        #2 rst = 1;
        #1;
        checks++;
        if ({acc_out, carry_flag, ovf_flag, count, in_ready, out_valid} !== '0) begin
            errors++;
            $display("FAIL reset_mid acc %h n %0d r %b v %b want zeros",
                     acc_out, count, in_ready, out_valid);
        end
        in_valid = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || acc_out !== '0) begin
            errors++;
            $display("FAIL post_reset_idle r %b acc %h want r 0 acc 0", in_ready, acc_out);
        end
    endtask

    task automatic test_basic();
        ops_d[0] = 32'd5; ops_s[0] = 0;
        ops_d[1] = 32'd7; ops_s[1] = 0;
        ops_d[2] = 32'hFFFF_FFF0; ops_s[2] = 0;
        run_stream(32'h0, 3, 0);
        collect(0);
    endtask

    task automatic test_sub_ovf();
        ops_d[0] = 32'd1; ops_s[0] = 1;
        run_stream(32'h8000_0000, 1, 0);
        collect(0);
        ops_d[0] = 32'd1; ops_s[0] = 0;
        run_stream(32'h7FFF_FFFF, 1, 0);
        collect(0);
    endtask

    task automatic test_backpressure();
        ops_d[0] = 32'hFFFF_FFFF; ops_s[0] = 0;
        ops_d[1] = 32'h0000_0003; ops_s[1] = 1;
        ops_d[2] = 32'h4000_0000; ops_s[2] = 0;
        run_stream(32'h4000_0000, 3, 0);
        collect(5);
    endtask

    task automatic test_gapped();
        for (int i = 0; i < 6; i++) begin
            ops_d[i] = $urandom;
            ops_s[i] = $urandom_range(0, 1);
        end
        run_stream($urandom, 6, 1);
        collect(0);
    endtask

    task automatic test_priority();
        @(negedge clk);
        start = 1; clear = 1; init = 32'hAAAA_5555;
        @(negedge clk);
        start = 0; clear = 0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || acc_out !== '0) begin
            errors++;
            $display("FAIL start_clear r %b v %b acc %h want 0 0 0", in_ready, out_valid, acc_out);
        end
        ops_d[0] = 32'h8000_0000; ops_s[0] = 0;
        ops_d[1] = 32'h8000_0001; ops_s[1] = 0;
        run_stream(32'h10, 2, 0);
        void'(sb.pop_front());
        clear = 1;
        @(negedge clk);
        clear = 0;
        checks++;
        if ({out_valid, in_ready, acc_out, carry_flag, ovf_flag, count} !== '0) begin
            errors++;
            $display("FAIL clear_done v %b acc %h c %b o %b n %0d want zeros",
                     out_valid, acc_out, carry_flag, ovf_flag, count);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            ops_d[i] = 32'd1; ops_s[i] = 0;
        end
        run_stream(32'h0, 20, 0);
        collect(0);
    endtask

    task automatic test_back_to_back();
        ops_d[0] = 32'h0000_0100; ops_s[0] = 1;
        run_stream(32'h0000_0010, 1, 0);
        collect(0);
        ops_d[0] = 32'h1; ops_s[0] = 0;
        ops_d[1] = 32'h2; ops_s[1] = 0;
        run_stream(32'hFFFF_FFFE, 2, 0);
        collect(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sub_ovf();
        test_backpressure();
        test_gapped();
        test_priority();
        test_saturation();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL queue_drain left %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
